window_mult: RTL and testbench
==============================

WINDOW_MULT -- requirements
Module: window_mult

Interface
REQ-001 Parameter KERNEL_SIZE, default 3, window length and number of product lanes.
REQ-002 Parameter DATA_WIDTH, default 8, unsigned pixel width.
REQ-003 Parameter WEIGHT_WIDTH, default 1, per-lane weight width; lane width RW = DATA_WIDTH+WEIGHT_WIDTH.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 pix_valid  input  1  pixel offered.
REQ-007 pix_data  input  DATA_WIDTH  pixel value.
REQ-008 pix_ready  output  1  pixel accepted when pix_valid && pix_ready.
REQ-009 win_clear  input  1  discard partial window and restart fill.
REQ-010 wgt_load  input  1  load weights.
REQ-011 wgt_data  input  WEIGHT_WIDTH*KERNEL_SIZE  packed weights; lane i at [(i+1)*WEIGHT_WIDTH-1 -: WEIGHT_WIDTH].
REQ-012 adder_en  output  1  one-cycle start pulse to the downstream adder tree.
REQ-013 adder_dataIn  output  RW*KERNEL_SIZE  packed products; lane i at [(i+1)*RW-1 -: RW].
REQ-014 adder_done  input  1  downstream accumulation complete.
REQ-015 win_count  output  16  windows issued, wraps at 16'hFFFF -> 0.

Function
REQ-016 States SHALL be FILL, ISSUE, WAIT; FILL is the reset state.
REQ-017 pix_ready SHALL be 1 only in FILL and 0 in ISSUE and WAIT.
REQ-018 Accepted pixels SHALL shift into a KERNEL_SIZE-deep window; lane 0 = oldest, lane KERNEL_SIZE-1 = newest.
REQ-019 fill_cnt SHALL count accepted pixels, saturating at KERNEL_SIZE.
REQ-020 When an accepted pixel makes the window full (fill_cnt reaches or stays at KERNEL_SIZE), the next state SHALL be ISSUE; stride is 1, so each pixel after the first KERNEL_SIZE-1 yields one window.
REQ-021 In ISSUE, the block SHALL register product_i = window_i * weight_i (unsigned, zero-extended to RW) into adder_dataIn, drive adder_en=1 for exactly that cycle, increment win_count, and go to WAIT.
REQ-022 adder_dataIn SHALL stay stable from the ISSUE cycle until the cycle after adder_done is sampled, because the adder reads lanes serially.
REQ-023 In WAIT, adder_done=1 SHALL return the FSM to FILL on the next edge; latency pixel-accept -> adder_en is 1 cycle.
REQ-024 adder_done outside WAIT SHALL be ignored.
REQ-025 wgt_load SHALL capture wgt_data only in FILL; in ISSUE/WAIT it is ignored and the weights are unchanged.
REQ-026 win_clear in FILL SHALL zero fill_cnt and the window; when it coincides with pix_valid, clear wins and the pixel is dropped (not accepted, pix_ready stays 1).
REQ-027 win_clear in ISSUE/WAIT SHALL be deferred: on return to FILL the fill restarts from zero.
REQ-028 When wgt_load and an accepted pixel occur in the same cycle, the new weights SHALL apply to the window issued next.

Reset
REQ-029 rst=1 SHALL asynchronously force FILL, fill_cnt=0, window=0, weights=0, adder_en=0, adder_dataIn=0, win_count=0, and pix_ready=1 after release.
REQ-030 Reset mid-WAIT SHALL abandon the window; a subsequent adder_done is ignored per REQ-024.

Configuration
REQ-031 Macro WINDOW_MULT_PM1_EN defined: each weight is its LSB only, bit 1 -> +pixel, bit 0 -> -pixel, as RW-bit two's complement; undefined: the unsigned multiply of REQ-021.

Verification
REQ-032 Params 3/8/1, weights 3'b111, pixels 10,20,30 -> one adder_en; lanes 10,20,30; win_count=1.
REQ-033 Same, then pixel 40 after adder_done -> lanes 20,30,40; win_count=2; pix_ready=0 from ISSUE until adder_done.
REQ-034 Weights 3'b101, pixels 255,7,9 -> lanes 255,0,9 (9-bit).
REQ-035 Pixels 5,6, then win_clear together with pix_valid(7), then 1,2,3 -> first adder_en only after pixel 3; lanes 1,2,3.
REQ-036 Assert rst in WAIT, then drive adder_done=1 -> all outputs zero, no adder_en, FILL.
REQ-037 WINDOW_MULT_PM1_EN, weights 3'b010, pixels 3,4,5 -> lanes 9'h1FD, 9'h004, 9'h1FB.

Source files
------------

// File: rtl/window_mult.sv
// window_mult: sliding pixel window multiplied lane-wise by weights, handed to a downstream adder tree.
// Optional build macro WINDOW_MULT_PM1_EN: each weight's LSB selects +pixel (1) or -pixel (0) in two's complement.
module window_mult #(
    parameter int KERNEL_SIZE  = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 pix_valid,
    input  logic [DATA_WIDTH-1:0]                                pix_data,
    output logic                                                 pix_ready,
    input  logic                                                 win_clear,
    input  logic                                                 wgt_load,
    input  logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0]                  wgt_data,
    output logic                                                 adder_en,
    output logic [(DATA_WIDTH+WEIGHT_WIDTH)*KERNEL_SIZE-1:0]     adder_dataIn,
    input  logic                                                 adder_done,
    output logic [15:0]                                          win_count
);
    localparam int RW = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int CW = $clog2(KERNEL_SIZE + 1);

    typedef enum logic [1:0] {FILL, ISSUE, WAIT} state_t;

    state_t                                      state, next_state;
    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]      win, win_next;
    logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0]         wgt, wgt_next;
    logic [CW-1:0]                               fill_cnt, fill_next;
    logic [RW*KERNEL_SIZE-1:0]                   prod;
    logic                                        clear_pend;
    logic                                        accept;
    logic                                        restart;
    logic                                        issue_now;

    assign accept    = (state == FILL) && pix_valid && !win_clear;
    assign restart   = (state == WAIT) && adder_done && (clear_pend || win_clear);
    assign issue_now = accept && (fill_next == CW'(KERNEL_SIZE));
    assign wgt_next  = (state == FILL && wgt_load) ? wgt_data : wgt;

    // Next window contents and fill level: clear, restart after a deferred clear, or shift in a pixel.
    always_comb begin
        win_next  = win;
        fill_next = fill_cnt;
        if ((state == FILL && win_clear) || restart) begin
            win_next  = '0;
            fill_next = '0;
        end else if (accept) begin
            for (int k = 0; k < KERNEL_SIZE - 1; k++)
                win_next[k] = win[k+1];
            win_next[KERNEL_SIZE-1] = pix_data;
            fill_next = (fill_cnt == CW'(KERNEL_SIZE)) ? fill_cnt : fill_cnt + CW'(1);
        end
    end

    // Products are formed from the window and weights as they will be after this edge,
    // so a same-cycle weight load applies to the window it completes.
    genvar g;
    generate
        for (g = 0; g < KERNEL_SIZE; g++) begin : g_lane
`ifdef WINDOW_MULT_PM1_EN
            assign prod[(g+1)*RW-1 -: RW] = wgt_next[g*WEIGHT_WIDTH]
                                          ? RW'(win_next[g])
                                          : RW'(0) - RW'(win_next[g]);
`else
            assign prod[(g+1)*RW-1 -: RW] = RW'(win_next[g])
                                          * RW'(wgt_next[(g+1)*WEIGHT_WIDTH-1 -: WEIGHT_WIDTH]);
`endif
        end
    endgenerate

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FILL;
            win          <= '0;
            fill_cnt     <= '0;
            wgt          <= '0;
            adder_dataIn <= '0;
            win_count    <= '0;
            clear_pend   <= 1'b0;
        end else begin
            state      <= next_state;
            win        <= win_next;
            fill_cnt   <= fill_next;
            wgt        <= wgt_next;
            clear_pend <= (state == FILL) ? 1'b0 : (clear_pend | win_clear);
            if (issue_now)
                adder_dataIn <= prod;
            if (state == ISSUE)
                win_count <= win_count + 16'd1;
        end
    end

    // Next-state logic: a full window issues, the issue lasts one cycle, then wait for the adder.
    always_comb begin
        case (state)
            FILL:    next_state = issue_now ? ISSUE : FILL;
            ISSUE:   next_state = WAIT;
            WAIT:    next_state = adder_done ? FILL : WAIT;
            default: next_state = FILL;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        pix_ready = (state == FILL);
        adder_en  = (state == ISSUE);
    end
endmodule

// File: tb/tb_window_mult.sv
// tb_window_mult: directed stimulus with a queue-based reference model checked every cycle.
module tb_window_mult;
    localparam int K  = 3;
    localparam int DW = 8;
    localparam int WW = 1;
    localparam int RW = DW + WW;

    logic              clk;
    logic              rst;
    logic              pix_valid;
    logic [DW-1:0]     pix_data;
    logic              pix_ready;
    logic              win_clear;
    logic              wgt_load;
    logic [WW*K-1:0]   wgt_data;
    logic              adder_en;
    logic [RW*K-1:0]   adder_dataIn;
    logic              adder_done;
    logic [15:0]       win_count;

    int n_vec = 0;
    int n_err = 0;

    window_mult #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .win_clear(win_clear), .wgt_load(wgt_load),
        .wgt_data(wgt_data), .adder_en(adder_en), .adder_dataIn(adder_dataIn),
        .adder_done(adder_done), .win_count(win_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pixels kept in a queue, window = last K accepted pixels.
    int              q[$];
    logic [K-1:0]    m_w;
    int              phase;
    logic            defer;
    logic [15:0]     m_cnt;
    logic [RW*K-1:0] m_lanes;

    function automatic logic [RW-1:0] lane(input int p, input logic b);
`ifdef WINDOW_MULT_PM1_EN
        return b ? RW'(p) : RW'(-p);
`else
        return RW'(p * int'(b));
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_w = '0; phase = 0; defer = 0; m_cnt = '0; m_lanes = '0;
        end else if (phase == 0) begin
            if (wgt_load) m_w = wgt_data;
            if (win_clear) q.delete();
            else if (pix_valid) begin
                q.push_back(int'(pix_data));
                if (q.size() > K) void'(q.pop_front());
                if (q.size() == K) begin
                    for (int i = 0; i < K; i++) m_lanes[i*RW +: RW] = lane(q[i], m_w[i]);
                    phase = 1;
                end
            end
        end else if (phase == 1) begin
            m_cnt++;
            defer |= win_clear;
            phase = 2;
        end else begin
            defer |= win_clear;
            if (adder_done) begin
                phase = 0;
                if (defer) begin q.delete(); defer = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_ready", 64'(pix_ready), 64'(phase == 0));
            chk("m_en", 64'(adder_en), 64'(phase == 1));
            chk("m_lanes", 64'(adder_dataIn), 64'(m_lanes));
            chk("m_count", 64'(win_count), 64'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int p);
        pix_valid = 1; pix_data = DW'(p);
        cyc();
        pix_valid = 0;
    endtask

    task automatic done();
        adder_done = 1;
        cyc();
        adder_done = 0;
    endtask

    task automatic finish_win();
        cyc();
        done();
    endtask

    task automatic load(input logic [K-1:0] w);
        wgt_load = 1; wgt_data = w;
        cyc();
        wgt_load = 0;
    endtask

    initial begin
        rst = 1; pix_valid = 0; pix_data = 0; win_clear = 0;
        wgt_load = 0; wgt_data = 0; adder_done = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_ready", 64'(pix_ready), 64'd1);
        chk("rst_en", 64'(adder_en), 64'd0);
        chk("rst_lanes", 64'(adder_dataIn), 64'd0);
        chk("rst_count", 64'(win_count), 64'd0);

        load(3'b111);
        push(10); push(20);
        chk("fill_no_en", 64'(adder_en), 64'd0);
        push(30);
        chk("t1_en", 64'(adder_en), 64'd1);
        chk("t1_lanes", 64'(adder_dataIn), 64'({9'd30, 9'd20, 9'd10}));
        chk("t1_ready", 64'(pix_ready), 64'd0);
        push(99);
        chk("t1_count", 64'(win_count), 64'd1);
        chk("t1_hold", 64'(adder_dataIn), 64'({9'd30, 9'd20, 9'd10}));
        load(3'b000);
        done();

        push(40);
        chk("t2_lanes", 64'(adder_dataIn), 64'({9'd40, 9'd30, 9'd20}));
        chk("t2_ready", 64'(pix_ready), 64'd0);
        cyc();
        chk("t2_count", 64'(win_count), 64'd2);
        done();
        done();
        chk("stray_done_en", 64'(adder_en), 64'd0);

        load(3'b101);
        push(255); finish_win();
        push(7);   finish_win();
        push(9);
        chk("t3_lanes", 64'(adder_dataIn), 64'({9'd9, 9'd0, 9'd255}));
        finish_win();

        wgt_load = 1; wgt_data = 3'b011;
        push(50);
        wgt_load = 0;
        chk("same_cycle_wgt", 64'(adder_dataIn), 64'({9'd0, 9'd9, 9'd7}));
        finish_win();

        load(3'b111);
        win_clear = 1; cyc(); win_clear = 0;
        push(5); push(6);
        win_clear = 1;
        chk("clear_ready", 64'(pix_ready), 64'd1);
        push(7);
        win_clear = 0;
        push(1); push(2);
        chk("t4_no_en", 64'(adder_en), 64'd0);
        push(3);
        chk("t4_en", 64'(adder_en), 64'd1);
        chk("t4_lanes", 64'(adder_dataIn), 64'({9'd3, 9'd2, 9'd1}));
        finish_win();

        push(11);
        win_clear = 1; cyc(); win_clear = 0;
        done();
        push(4); push(5);
        chk("defer_no_en", 64'(adder_en), 64'd0);
        push(6);
        chk("defer_lanes", 64'(adder_dataIn), 64'({9'd6, 9'd5, 9'd4}));
        cyc();

        rst = 1;
        #2;
        chk("wait_rst_en", 64'(adder_en), 64'd0);
        chk("wait_rst_lanes", 64'(adder_dataIn), 64'd0);
        chk("wait_rst_count", 64'(win_count), 64'd0);
        adder_done = 1;
        cyc();
        rst = 0;
        cyc();
        adder_done = 0;
        chk("post_rst_en", 64'(adder_en), 64'd0);
        chk("post_rst_ready", 64'(pix_ready), 64'd1);
        chk("post_rst_count", 64'(win_count), 64'd0);

        load(3'b010);
        push(3); push(4); push(5);
`ifdef WINDOW_MULT_PM1_EN
        chk("pm1_lanes", 64'(adder_dataIn), 64'({9'h1FB, 9'h004, 9'h1FD}));
`else
        chk("w010_lanes", 64'(adder_dataIn), 64'({9'h000, 9'h004, 9'h000}));
`endif
        finish_win();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
